multicycle_adder: RTL and testbench
===================================

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter N, default 32: operand width in bits.
REQ-002 Parameter W, default 8: chunk width added per cycle; N SHALL be an integer multiple of W, and W SHALL NOT exceed N.
REQ-003 Derived constant K = N/W: chunk count and BUSY cycle count. Counter width SHALL be max(1, $clog2(K)).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operands and mode valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  N  operand A.
REQ-009 b  input  N  operand B.
REQ-010 c_in  input  1  carry-in for add mode; ignored when sub=1.
REQ-011 sub  input  1  0 = A+B+c_in, 1 = A-B (A + ~B + 1).
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 sum  output  N  result, modulo 2^N.
REQ-015 c_out  output  1  carry out of bit N-1; in sub mode, 1 = no borrow.
REQ-016 ovf  output  1  two's-complement overflow: carry into bit N-1 XOR carry out of bit N-1.

Function
REQ-017 FSM states SHALL be IDLE, BUSY and DONE.
REQ-018 In IDLE, in_ready=1. In BUSY and DONE, in_ready=0.
REQ-019 Accept SHALL occur when in_valid && in_ready at a clock edge. At accept, the block SHALL latch a, b XOR {N{sub}}, and carry = sub ? 1 : c_in; it SHALL clear the chunk index and transition IDLE->BUSY.
REQ-020 In BUSY, each cycle SHALL add chunk k (bits k*W+W-1 : k*W) of the latched operands plus the running carry. It SHALL write that slice of sum, update the carry and increment k.
REQ-021 On the edge that processes chunk K-1, the FSM SHALL move BUSY->DONE, capture c_out and ovf, and set out_valid=1.
REQ-022 out_valid SHALL rise exactly K clock edges after the accept edge; K=1 SHALL work, with a single BUSY cycle.
REQ-023 In DONE, sum, c_out, ovf and out_valid SHALL remain stable until out_valid && out_ready. On that edge the FSM SHALL go DONE->IDLE and out_valid SHALL fall to 0.
REQ-024 sum, c_out and ovf SHALL hold their last values in IDLE until the next result.
REQ-025 in_valid, a, b, c_in and sub SHALL be ignored outside IDLE; no input is queued.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 No combinational path SHALL exist from any input to any output.

Reset
REQ-028 On rst_n low, the block SHALL immediately force state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, chunk index=0 and internal carry=0.
REQ-029 Reset during BUSY or DONE SHALL discard the operation; no partial result SHALL be presented after release.
REQ-030 After rst_n rises, the first accept SHALL be possible on the first clock edge.

Structure
REQ-031 Package adder_pkg SHALL hold the state enum typedef (IDLE, BUSY, DONE) and the default N/W constants.
REQ-032 The per-chunk combinational adder SHALL be one sub-module, chunk_adder, parameterised by W. Its outputs SHALL be the W-bit sum, carry out, and carry into its MSB (for ovf).
REQ-033 Exactly one chunk_adder instance SHALL be time-multiplexed across chunks.

Verification (N=32, W=8 unless stated)
REQ-034 Reset then idle -> in_ready=1, out_valid=0, sum=0x00000000, c_out=0, ovf=0.
REQ-035 a=0x000000FF, b=0x00000001, c_in=0, sub=0 -> sum=0x00000100, c_out=0, ovf=0, out_valid exactly 4 edges after accept.
REQ-036 a=0xFFFFFFFF, b=0x00000001, c_in=0 -> sum=0x00000000, c_out=1, ovf=0. Then a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, c_out=0, ovf=1.
REQ-037 sub=1, a=0x00000005, b=0x00000007, c_in=1 -> sum=0xFFFFFFFE, c_out=0, ovf=0; c_in has no effect.
REQ-038 Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not accepted. Then out_ready=1 -> IDLE the next cycle.
REQ-039 rst_n low for one cycle during BUSY chunk 2 -> IDLE with all outputs 0. Also rerun REQ-035 with N=8, W=8 (K=1) -> out_valid 1 edge after accept.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and default sizing for the multicycle adder.
// Operand width defaults to 32 bits, added 8 bits per cycle.
package adder_pkg;
    localparam int N_DEF = 32;
    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/multicycle_adder_if.sv
// Operand/result handshake bundle for multicycle_adder.
// slave is the adder side; master is the producer/consumer side.
interface multicycle_adder_if
    import adder_pkg::*;
#(
    parameter int N = N_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
    logic         ovf;

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/chunk_adder.sv
// W-bit combinational adder slice; also reports the carry into its MSB
// so the caller can form two's-complement overflow on the top chunk.
module chunk_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out directly.
    assign c_msb = s[W-1] ^ a[W-1] ^ b[W-1];
endmodule

// File: rtl/multicycle_adder.sv
// N-bit adder/subtractor that processes one W-bit chunk per cycle through a
// single shared chunk_adder; valid/ready on both the operand and result side.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_adder_if.slave   bus
);
    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    state_e         state;
    logic [CW-1:0]  k;
    logic [N-1:0]   ra;
    logic [N-1:0]   rb;
    logic [N-1:0]   sum_r;
    logic           carry;
    logic           c_out_r;
    logic           ovf_r;

    logic [W-1:0]   ca;
    logic [W-1:0]   cb;
    logic [W-1:0]   cs;
    logic           co;
    logic           cm;

    assign ca = ra[int'(k)*W +: W];
    assign cb = rb[int'(k)*W +: W];

    chunk_adder #(.W(W)) u_chunk (
        .a     (ca),
        .b     (cb),
        .cin   (carry),
        .s     (cs),
        .cout  (co),
        .c_msb (cm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            ra      <= '0;
            rb      <= '0;
            carry   <= 1'b0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    // Subtract is A + ~B + 1; c_in is irrelevant then.
                    ra    <= bus.a;
                    rb    <= bus.b ^ {N{bus.sub}};
                    carry <= bus.sub | bus.c_in;
                    k     <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    sum_r[int'(k)*W +: W] <= cs;
                    carry <= co;
                    if (k == CW'(K-1)) begin
                        c_out_r <= co;
                        ovf_r   <= co ^ cm;
                        k       <= '0;
                        state   <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs come straight from state: no input-to-output path.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.c_out     = c_out_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_multicycle_adder.sv
// Randomised and directed bench for multicycle_adder: a transaction-level
// model predicts handshake and result every cycle; literals pin key cases.
module tb_multicycle_adder;
    import adder_pkg::*;

    localparam int K = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_adder_if #(.N(32)) bus0 ();
    multicycle_adder_if #(.N(8))  bus1 ();

    multicycle_adder #(.N(32), .W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    multicycle_adder #(.N(8),  .W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                    input logic ci, input logic sb,
                                    output logic [31:0] s, output logic co, output logic ov);
        logic [31:0] bb;
        logic [32:0] f;
        bb = sb ? ~b : b;
        f  = {1'b0, a} + {1'b0, bb} + 33'(sb ? 1'b1 : ci);
        s  = f[31:0];
        co = f[32];
        ov = (a[31] == bb[31]) && (f[31] != a[31]);
    endfunction

    // Transaction model: phase 0 idle, 1 computing, 2 result presented.
    int          m_phase;
    int          m_left;
    logic [31:0] m_sum, p_sum;
    logic        m_c, m_o, p_c, p_o;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_left = 0;
            m_sum = '0; m_c = 1'b0; m_o = 1'b0;
        end else begin
            case (m_phase)
                0: if (bus0.in_valid) begin
                    ref_add(bus0.a, bus0.b, bus0.c_in, bus0.sub, p_sum, p_c, p_o);
                    m_left = K;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_sum = p_sum; m_c = p_c; m_o = p_o;
                    end
                end
                default: if (bus0.out_ready) m_phase = 0;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("in_ready", 64'(bus0.in_ready), 64'(m_phase == 0));
            chk("out_valid", 64'(bus0.out_valid), 64'(m_phase == 2));
            if (m_phase != 1) begin
                chk("sum", 64'(bus0.sum), 64'(m_sum));
                chk("c_out", 64'(bus0.c_out), 64'(m_c));
                chk("ovf", 64'(bus0.ovf), 64'(m_o));
            end
        end
    end

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                      input logic sb, input int hold,
                      output logic [31:0] s, output logic co, output logic ov, output int lat);
        @(negedge clk);
        chk("ready_before_accept", 64'(bus0.in_ready), 64'd1);
        bus0.a = a; bus0.b = b; bus0.c_in = ci; bus0.sub = sb; bus0.in_valid = 1'b1;
        @(negedge clk);
        lat = 0;
        bus0.in_valid = (hold > 0);
        while (!bus0.out_valid && lat < 20) begin
            if (hold > 0) begin bus0.a = $urandom; bus0.b = $urandom; bus0.sub = 1'($urandom); end
            @(negedge clk);
            lat++;
        end
        if (!bus0.out_valid) chk("result_timeout", 64'd0, 64'd1);
        s = bus0.sum; co = bus0.c_out; ov = bus0.ovf;
        repeat (hold) begin
            bus0.a = $urandom; bus0.b = $urandom; bus0.c_in = 1'($urandom);
            @(negedge clk);
            chk("hold_sum", 64'(bus0.sum), 64'(s));
            chk("hold_valid", 64'(bus0.out_valid), 64'd1);
            chk("hold_in_ready", 64'(bus0.in_ready), 64'd0);
        end
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 64'(bus0.out_valid), 64'd0);
        chk("release_in_ready", 64'(bus0.in_ready), 64'd1);
        bus0.out_ready = 1'b0;
    endtask

    task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic sb,
                       output logic [7:0] s, output logic co, output logic ov, output int lat);
        @(negedge clk);
        bus1.a = a; bus1.b = b; bus1.c_in = 1'b0; bus1.sub = sb; bus1.in_valid = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = bus1.sum; co = bus1.c_out; ov = bus1.ovf;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] s;
        logic [7:0]  s8;
        logic        co, ov;
        int          lat;

        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.c_in = 1'b0; bus0.sub = 1'b0;
        bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0; bus1.sub = 1'b0;
        bus1.out_ready = 1'b1;

        // Pin the reference model against hand-computed results.
        ref_add(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, s, co, ov);
        chk("model_ovf", {31'd0, ov, co, s}, {31'd0, 1'b1, 1'b0, 32'h80000000});
        ref_add(32'h5, 32'h7, 1'b1, 1'b1, s, co, ov);
        chk("model_sub", {31'd0, ov, co, s}, {31'd0, 1'b0, 1'b0, 32'hFFFFFFFE});

        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(bus0.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst_sum", 64'(bus0.sum), 64'd0);
        chk("rst_flags", {62'd0, bus0.c_out, bus0.ovf}, 64'd0);

        op(32'h000000FF, 32'h1, 1'b0, 1'b0, 0, s, co, ov, lat);
        chk("ff_plus_1", {30'd0, ov, co, s}, {30'd0, 1'b0, 1'b0, 32'h00000100});
        chk("latency_k4", 64'(lat), 64'd4);
        op(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 0, s, co, ov, lat);
        chk("wrap_carry", {30'd0, ov, co, s}, {30'd0, 1'b0, 1'b1, 32'h0});
        op(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 0, s, co, ov, lat);
        chk("signed_ovf", {30'd0, ov, co, s}, {30'd0, 1'b1, 1'b0, 32'h80000000});
        op(32'h5, 32'h7, 1'b1, 1'b1, 0, s, co, ov, lat);
        chk("sub_cin1", {30'd0, ov, co, s}, {30'd0, 1'b0, 1'b0, 32'hFFFFFFFE});
        op(32'h5, 32'h7, 1'b0, 1'b1, 0, s, co, ov, lat);
        chk("sub_cin0", {30'd0, ov, co, s}, {30'd0, 1'b0, 1'b0, 32'hFFFFFFFE});
        op(32'h12345678, 32'h11111111, 1'b1, 1'b0, 10, s, co, ov, lat);
        chk("hold_result", {30'd0, ov, co, s}, {30'd0, 1'b0, 1'b0, 32'h2345678A});

        // Reset while chunk 2 is pending, then accept on the first edge after release.
        @(negedge clk);
        bus0.a = 32'hFFFF0000; bus0.b = 32'h0001FFFF; bus0.c_in = 1'b0; bus0.sub = 1'b0;
        bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(bus0.in_ready), 64'd1);
        chk("midrst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("midrst_sum", 64'(bus0.sum), 64'd0);
        chk("midrst_flags", {62'd0, bus0.c_out, bus0.ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus0.a = 32'h80000000; bus0.b = 32'h80000000; bus0.in_valid = 1'b1;
        @(negedge clk);
        chk("first_edge_accept", 64'(bus0.in_ready), 64'd0);
        bus0.in_valid = 1'b0;
        repeat (K) @(negedge clk);
        chk("post_rst_result", {30'd0, bus0.ovf, bus0.c_out, bus0.sum}, {30'd0, 1'b1, 1'b1, 32'h0});
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 4))
                0: ra = 32'hFFFFFFFF;
                1: ra = 32'h7FFFFFFF;
                2: rb = 32'h80000000;
                default: ;
            endcase
            op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), s, co, ov, lat);
            chk("rand_latency", 64'(lat), 64'd4);
        end

        chk_en = 1'b0;
        op1(8'hFF, 8'h01, 1'b0, s8, co, ov, lat);
        chk("k1_latency", 64'(lat), 64'd1);
        chk("k1_wrap", {54'd0, ov, co, s8}, {54'd0, 1'b0, 1'b1, 8'h00});
        op1(8'h7F, 8'h01, 1'b0, s8, co, ov, lat);
        chk("k1_ovf", {54'd0, ov, co, s8}, {54'd0, 1'b1, 1'b0, 8'h80});
        op1(8'h05, 8'h07, 1'b1, s8, co, ov, lat);
        chk("k1_sub", {54'd0, ov, co, s8}, {54'd0, 1'b0, 1'b0, 8'hFE});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
